// File: rtl/i2c_slave_fsm.sv
//============================================================================
// Module   : i2c_slave_fsm
// Brief    : I2C responder with a fixed 7-bit address. It ACKs a matching
//            address, then captures two write bytes or returns two read bytes.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module i2c_slave_fsm #(
    parameter int                    ADDR_LEN   = 7,
    parameter int                    DATA_LEN   = 8,
    parameter logic [ADDR_LEN-1:0]   SLAVE_ADDR = 7'b1010110
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scl,
    input  logic                sda_in,
    output logic                sda_oe,
    input  logic [DATA_LEN-1:0] tx_data_1,
    input  logic [DATA_LEN-1:0] tx_data_2,
    output logic [DATA_LEN-1:0] rx_data_1,
    output logic [DATA_LEN-1:0] rx_data_2,
    output logic                rx_valid,
    output logic                rd_done,
    output logic                busy
);

    localparam int MAX_LEN = (ADDR_LEN + 1 > DATA_LEN) ? ADDR_LEN + 1 : DATA_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] C_ADDR_BITS = CNT_W'(ADDR_LEN + 1);
    localparam logic [CNT_W-1:0] C_DATA_BITS = CNT_W'(DATA_LEN);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_ADDR_ACK  = 3'd2,
        S_RX_DATA   = 3'd3,
        S_RX_ACK    = 3'd4,
        S_TX_DATA   = 3'd5,
        S_TX_ACK    = 3'd6,
        S_WAIT_STOP = 3'd7
    } state_t;

    // Bus conditioning: two sync stages plus one history stage per line.
    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;

    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    state_t                 state_q,   state_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic                   idx_q,     idx_d;
    logic                   rw_q,      rw_d;
    logic [ADDR_LEN:0]      addr_sr_q, addr_sr_d;
    logic [DATA_LEN-1:0]    rx_sr_q,   rx_sr_d;
    logic [DATA_LEN-1:0]    tx_sr_q,   tx_sr_d;
    logic [DATA_LEN-1:0]    tx2_q,     tx2_d;
    logic [DATA_LEN-1:0]    rx1_q,     rx1_d;
    logic [DATA_LEN-1:0]    rx2_q,     rx2_d;
    logic                   sda_oe_q,  sda_oe_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rd_done_q, rd_done_d;
    logic                   busy_q,    busy_d;

    assign w_scl_rise = scl_sync_q & ~scl_prev_q;
    assign w_scl_fall = ~scl_sync_q & scl_prev_q;
    assign w_start    = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
    assign w_stop     = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Idle bus level is high, so the conditioning chain resets high
            // to avoid a phantom edge on the first cycle after reset.
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= 1'b0;
            rw_q       <= 1'b0;
            addr_sr_q  <= '0;
            rx_sr_q    <= '0;
            tx_sr_q    <= '0;
            tx2_q      <= '0;
            rx1_q      <= '0;
            rx2_q      <= '0;
            sda_oe_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_meta_q <= scl;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda_in;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rw_q       <= rw_d;
            addr_sr_q  <= addr_sr_d;
            rx_sr_q    <= rx_sr_d;
            tx_sr_q    <= tx_sr_d;
            tx2_q      <= tx2_d;
            rx1_q      <= rx1_d;
            rx2_q      <= rx2_d;
            sda_oe_q   <= sda_oe_d;
            rx_valid_q <= rx_valid_d;
            rd_done_q  <= rd_done_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rw_d       = rw_q;
        addr_sr_d  = addr_sr_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        tx2_d      = tx2_q;
        rx1_d      = rx1_q;
        rx2_d      = rx2_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        rd_done_d  = 1'b0;

        // Bus conditions win over any scl edge seen in the same cycle.
        if (w_start) begin
            state_d  = S_ADDR;
            cnt_d    = '0;
            idx_d    = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (w_stop) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            idx_d    = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end

                S_ADDR: begin
                    if (w_scl_rise && cnt_q != C_ADDR_BITS) begin
                        addr_sr_d = {addr_sr_q[ADDR_LEN-1:0], sda_sync_q};
                        cnt_d     = cnt_q + C_ONE;
                    end else if (w_scl_fall && cnt_q == C_ADDR_BITS) begin
                        cnt_d = '0;
                        if (addr_sr_q[ADDR_LEN:1] == SLAVE_ADDR) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = addr_sr_q[0];
                            tx_sr_d  = tx_data_1;
                            tx2_d    = tx_data_2;
                            idx_d    = 1'b0;
                            state_d  = S_ADDR_ACK;
                        end else begin
                            state_d  = S_IDLE;
                        end
                    end
                end

                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (rw_q) begin
                            // Release of the ACK and the read MSB share this fall.
                            sda_oe_d = ~tx_sr_q[DATA_LEN-1];
                            tx_sr_d  = {tx_sr_q[DATA_LEN-2:0], 1'b0};
                            cnt_d    = C_ONE;
                            state_d  = S_TX_DATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = S_RX_DATA;
                        end
                    end
                end

                S_RX_DATA: begin
                    if (w_scl_rise && cnt_q != C_DATA_BITS) begin
                        rx_sr_d = {rx_sr_q[DATA_LEN-2:0], sda_sync_q};
                        cnt_d   = cnt_q + C_ONE;
                    end else if (w_scl_fall && cnt_q == C_DATA_BITS) begin
                        if (idx_q) begin
                            rx2_d      = rx_sr_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            rx1_d      = rx_sr_q;
                        end
                        sda_oe_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = S_RX_ACK;
                    end
                end

                S_RX_ACK: begin
                    if (w_scl_fall) begin
                        sda_oe_d = 1'b0;
                        if (idx_q) begin
                            state_d = S_WAIT_STOP;
                        end else begin
                            idx_d   = 1'b1;
                            state_d = S_RX_DATA;
                        end
                    end
                end

                S_TX_DATA: begin
                    if (w_scl_fall) begin
                        if (cnt_q == C_DATA_BITS) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = S_TX_ACK;
                        end else begin
                            sda_oe_d = ~tx_sr_q[DATA_LEN-1];
                            tx_sr_d  = {tx_sr_q[DATA_LEN-2:0], 1'b0};
                            cnt_d    = cnt_q + C_ONE;
                        end
                    end
                end

                S_TX_ACK: begin
                    if (w_scl_rise) begin
                        if (!sda_sync_q && !idx_q) begin
                            // cnt=0 makes the next fall in S_TX_DATA drive the MSB.
                            tx_sr_d = tx2_q;
                            idx_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = S_TX_DATA;
                        end else begin
                            rd_done_d = 1'b1;
                            state_d   = S_WAIT_STOP;
                        end
                    end
                end

                S_WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = S_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe    = sda_oe_q;
    assign rx_data_1 = rx1_q;
    assign rx_data_2 = rx2_q;
    assign rx_valid  = rx_valid_q;
    assign rd_done   = rd_done_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire
